// File: rtl/stack_pointer_unit.sv
// Execute-stage stack pointer: decodes push/pop, checks bounds, updates SP and
// registers the stack address and exception pulses for the memory stage.
module stack_pointer_unit #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] SP_RESET = 20'hFFFFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 20'h00800
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_en32,
    input  logic [31:0]       i_pc,
    output logic [31:0]       o_stackData,
    output logic              o_isStack,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_overflowExc,
    output logic              o_emptyExc,
    output logic [31:0]       o_excPc
);

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] stack_addr_q, stack_addr_d;
    logic              is_stack_q, is_stack_d;
    logic              overflow_q, overflow_d;
    logic              empty_q, empty_d;
    logic [31:0]       exc_pc_q, exc_pc_d;

    logic [ADDR_W:0]   n_wide;
    logic [ADDR_W:0]   push_lo;
    logic [ADDR_W:0]   pop_hi;
    logic              push_ok;
    logic              pop_ok;
    logic              do_push;
    logic              do_pop;

    // One extra bit on the bound checks so a wrap shows up as a borrow/carry.
    always_comb begin
        n_wide  = i_en32 ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
        push_lo = {1'b0, sp_q} - {{ADDR_W{1'b0}}, i_en32};
        pop_hi  = {1'b0, sp_q} + n_wide;
        push_ok = !push_lo[ADDR_W] && (push_lo >= {1'b0, SP_LIMIT});
        pop_ok  = pop_hi <= {1'b0, SP_RESET};
        do_push = i_push;
        do_pop  = i_pop && !i_push;
    end

    always_comb begin
        sp_d         = sp_q;
        stack_addr_d = stack_addr_q;
        is_stack_d   = is_stack_q;
        overflow_d   = overflow_q;
        empty_d      = empty_q;
        exc_pc_d     = exc_pc_q;
        if (i_flush) begin
            stack_addr_d = '0;
            is_stack_d   = 1'b0;
            overflow_d   = 1'b0;
            empty_d      = 1'b0;
        end else if (!i_stall) begin
            stack_addr_d = '0;
            is_stack_d   = 1'b0;
            overflow_d   = 1'b0;
            empty_d      = 1'b0;
            if (do_push) begin
                if (push_ok) begin
                    is_stack_d   = 1'b1;
                    stack_addr_d = push_lo[ADDR_W-1:0];
                    sp_d         = sp_q - n_wide[ADDR_W-1:0];
                end else begin
                    overflow_d = 1'b1;
                    exc_pc_d   = i_pc;
                end
            end else if (do_pop) begin
                if (pop_ok) begin
                    is_stack_d   = 1'b1;
                    stack_addr_d = sp_q + ADDR_W'(1);
                    sp_d         = pop_hi[ADDR_W-1:0];
                end else begin
                    empty_d  = 1'b1;
                    exc_pc_d = i_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sp_q         <= SP_RESET;
            stack_addr_q <= '0;
            is_stack_q   <= 1'b0;
            overflow_q   <= 1'b0;
            empty_q      <= 1'b0;
            exc_pc_q     <= '0;
        end else begin
            sp_q         <= sp_d;
            stack_addr_q <= stack_addr_d;
            is_stack_q   <= is_stack_d;
            overflow_q   <= overflow_d;
            empty_q      <= empty_d;
            exc_pc_q     <= exc_pc_d;
        end
    end

    assign o_stackData   = {{(32-ADDR_W){1'b0}}, stack_addr_q};
    assign o_isStack     = is_stack_q;
    assign o_sp          = sp_q;
    assign o_overflowExc = overflow_q;
    assign o_emptyExc    = empty_q;
    assign o_excPc       = exc_pc_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: directed scenarios plus random traffic checked
// every cycle against an integer-arithmetic model of the stack rules.
module tb_stack_pointer_unit;

    localparam int          ADDR_W = 20;
    localparam logic [19:0] RST_SP = 20'hFFFFF;
    // Limit raised near the top so the overflow boundary is reachable quickly.
    localparam logic [19:0] LIM_SP = 20'hFFF00;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic        i_push = 1'b0, i_pop = 1'b0, i_en32 = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] o_stackData;
    logic        o_isStack;
    logic [19:0] o_sp;
    logic        o_overflowExc, o_emptyExc;
    logic [31:0] o_excPc;

    int total = 0;
    int bad   = 0;

    int          m_sp = RST_SP;
    int          m_data = 0;
    bit          m_is = 0, m_ov = 0, m_em = 0;
    logic [31:0] m_epc = '0;

    stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_RESET(RST_SP), .SP_LIMIT(LIM_SP)) dut (
        .clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_push(i_push), .i_pop(i_pop), .i_en32(i_en32), .i_pc(i_pc),
        .o_stackData(o_stackData), .o_isStack(o_isStack), .o_sp(o_sp),
        .o_overflowExc(o_overflowExc), .o_emptyExc(o_emptyExc), .o_excPc(o_excPc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: word-count arithmetic on plain ints, evaluated at the clock edge.
    task automatic model_edge();
        int n;
        n = i_en32 ? 2 : 1;
        if (i_reset) begin
            m_sp = RST_SP; m_data = 0; m_is = 0; m_ov = 0; m_em = 0; m_epc = '0;
        end else if (i_flush) begin
            m_data = 0; m_is = 0; m_ov = 0; m_em = 0;
        end else if (!i_stall) begin
            m_data = 0; m_is = 0; m_ov = 0; m_em = 0;
            if (i_push) begin
                if (m_sp - (n - 1) >= int'(LIM_SP) && m_sp >= n - 1) begin
                    m_is = 1; m_data = m_sp - (n - 1); m_sp = m_sp - n;
                end else begin
                    m_ov = 1; m_epc = i_pc;
                end
            end else if (i_pop) begin
                if (m_sp + n <= int'(RST_SP)) begin
                    m_is = 1; m_data = m_sp + 1; m_sp = m_sp + n;
                end else begin
                    m_em = 1; m_epc = i_pc;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic fl, input logic pu,
                        input logic po, input logic e32, input logic [31:0] pc);
        i_reset = rst; i_stall = st; i_flush = fl;
        i_push = pu; i_pop = po; i_en32 = e32; i_pc = pc;
        @(posedge clk);
        model_edge();
        #1;
        chk("sp", 32'(o_sp), 32'(m_sp));
        chk("stackData", o_stackData, 32'(m_data));
        chk("isStack", 32'(o_isStack), 32'(m_is));
        chk("overflowExc", 32'(o_overflowExc), 32'(m_ov));
        chk("emptyExc", 32'(o_emptyExc), 32'(m_em));
        chk("excPc", o_excPc, m_epc);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_sp", 32'(o_sp), 32'h000FFFFF);
        chk("rst_isStack", 32'(o_isStack), 32'h0);

        // 16-bit push from reset
        step(0, 0, 0, 1, 0, 0, 0);
        chk("push16_addr", o_stackData, 32'h000FFFFF);
        chk("push16_sp", 32'(o_sp), 32'h000FFFFE);

        // 32-bit push then 32-bit pop
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        chk("push32_addr", o_stackData, 32'h000FFFFE);
        chk("push32_sp", 32'(o_sp), 32'h000FFFFD);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("pop32_addr", o_stackData, 32'h000FFFFE);
        chk("pop32_sp", 32'(o_sp), 32'h000FFFFF);

        // Pop from empty stack, then pulse drops but excPc holds
        step(0, 0, 0, 0, 1, 0, 32'h123);
        chk("empty_pulse", 32'(o_emptyExc), 32'h1);
        chk("empty_pc", o_excPc, 32'h123);
        chk("empty_sp", 32'(o_sp), 32'h000FFFFF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("empty_one_cycle", 32'(o_emptyExc), 32'h0);
        chk("excpc_hold", o_excPc, 32'h123);

        // 32-bit pop with one word on the stack faults
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h456);
        chk("pop32_short", 32'(o_emptyExc), 32'h1);
        chk("pop32_short_sp", 32'(o_sp), 32'h000FFFFE);

        // Walk down to the limit: SP=FFFFE, 127 x 32-bit pushes -> LIM_SP
        for (int i = 0; i < 127; i++) step(0, 0, 0, 1, 0, 1, 0);
        chk("at_limit", 32'(o_sp), 32'(LIM_SP));
        step(0, 0, 0, 1, 0, 1, 32'h789);
        chk("ovf32_pulse", 32'(o_overflowExc), 32'h1);
        chk("ovf32_sp", 32'(o_sp), 32'(LIM_SP));
        chk("ovf32_pc", o_excPc, 32'h789);
        // Stall keeps the pulse register as is
        step(0, 1, 0, 1, 0, 0, 0);
        chk("stall_hold_pulse", 32'(o_overflowExc), 32'h1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("limit16_addr", o_stackData, 32'(LIM_SP));
        chk("limit16_ok", 32'(o_overflowExc), 32'h0);
        step(0, 0, 0, 1, 0, 0, 32'hABC);
        chk("below_limit_ovf", 32'(o_overflowExc), 32'h1);

        // Stalled push: frozen for 3 cycles, one decrement on release
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0);
        chk("stall_sp", 32'(o_sp), 32'h000FFFFF);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("release_sp", 32'(o_sp), 32'h000FFFFE);

        // Flushed push (also with stall: flush wins)
        step(0, 0, 1, 1, 0, 0, 0);
        chk("flush_is", 32'(o_isStack), 32'h0);
        chk("flush_sp", 32'(o_sp), 32'h000FFFFE);
        step(0, 1, 1, 1, 0, 1, 0);

        // Push and pop together behaves as a push
        step(0, 0, 0, 1, 1, 0, 0);
        chk("both_sp", 32'(o_sp), 32'h000FFFFD);

        // Reset during stalled 32-bit push
        step(1, 1, 0, 1, 0, 1, 32'hDEAD);
        chk("rst_stall_sp", 32'(o_sp), 32'h000FFFFF);
        chk("rst_stall_is", 32'(o_isStack), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic rst, st, fl, pu, po;
            rst = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 5) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            pu  = ($urandom_range(0, 1) == 0);
            po  = ($urandom_range(0, 1) == 0);
            step(rst, st, fl, pu, po, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
